// File: rtl/hotspot_overlay_multi.sv
// hotspot_overlay_multi
// Composites up to NUM_SPOTS sprite copies onto an RGB565 pixel stream.
// Positions are clamped on capture, held in shadow registers and moved to
// the active set on the rising edge of vs_in, so a frame never tears.
// Pipeline: S1 hit test -> S2 priority select / ROM address -> ROM -> mix.
// The final mix is combinational on rom_data so that h_cnt -> rgb_out is
// exactly ROM_LAT+2 cycles; every input it uses comes from a flop or from
// the ROM's registered output.
module hotspot_overlay_multi #(
    parameter int          NUM_SPOTS = 4,
    parameter int          SPOT_SIZE = 49,
    parameter int          H_RES     = 480,
    parameter int          V_RES     = 272,
    parameter int          ROM_LAT   = 1,
    parameter logic [15:0] TRANSP    = 16'h0000,
    parameter int          ADDR_W    = 12
) (
    input  logic                        clk_pix,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic [32*NUM_SPOTS-1:0]     pix_x_in,
    input  logic [32*NUM_SPOTS-1:0]     pix_y_in,
    input  logic [NUM_SPOTS-1:0]        spot_en,
    input  logic                        blend_mode,
    input  logic [15:0]                 h_cnt,
    input  logic [15:0]                 v_cnt,
    input  logic                        de_in,
    input  logic                        hs_in,
    input  logic                        vs_in,
    input  logic [15:0]                 bg_rgb,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [15:0]                 rom_data,
    output logic                        de_out,
    output logic                        hs_out,
    output logic                        vs_out,
    output logic [15:0]                 rgb_out,
    output logic [$clog2(NUM_SPOTS):0]  hit_idx
);

    localparam int RADIUS = (SPOT_SIZE - 1) / 2;
    localparam int HIT_W  = $clog2(NUM_SPOTS) + 1;
    localparam int OFF_W  = $clog2(SPOT_SIZE);
    localparam int LAT    = ROM_LAT + 2;
    localparam int TM_W   = 20;
    localparam logic [HIT_W-1:0]  NO_HIT = '1;
    localparam logic signed [16:0] RAD_P = 17'(RADIUS);
    localparam logic signed [16:0] RAD_N = 17'(-RADIUS);

    // Saturate a signed 32-bit coordinate into [0, hi].
    function automatic logic [15:0] clamp(input logic signed [31:0] v, input int hi);
        if (v < 0)
            return 16'h0000;
        else if (v > hi)
            return 16'(hi);
        else
            return v[15:0];
    endfunction

    // Position state
    logic [NUM_SPOTS-1:0][15:0] shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
    logic [NUM_SPOTS-1:0][15:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic [NUM_SPOTS-1:0]       shadow_en_q, shadow_en_d, act_en_q, act_en_d;
    logic                       vs_prev_q;
    logic                       commit;

    // Per-spot combinational results
    logic [NUM_SPOTS-1:0][15:0]      x_clamp, y_clamp;
    logic [NUM_SPOTS-1:0]            spot_hit;
    logic [NUM_SPOTS-1:0][OFF_W-1:0] spot_dx, spot_dy;

    // Stage S1
    logic [NUM_SPOTS-1:0]            s1_hit_q, s1_hit_d;
    logic [NUM_SPOTS-1:0][OFF_W-1:0] s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;

    // Stage S2
    logic [HIT_W-1:0]  sel_idx;
    logic [OFF_W-1:0]  sel_dx, sel_dy;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [HIT_W-1:0]  s2_idx_q, s2_idx_d;

    // Delay lines: timing/background for LAT cycles, hit index for ROM_LAT
    logic [LAT-1:0][TM_W-1:0]      tm_q, tm_d;
    logic [ROM_LAT-1:0][HIT_W-1:0] hit_q, hit_d;

    // Output-side views of the delay lines
    logic        mode_dly, de_dly, hs_dly, vs_dly, pix_hit;
    logic [15:0] bg_dly;
    logic [5:0]  r_sum, b_sum;
    logic [6:0]  g_sum;

    assign commit = vs_in & ~vs_prev_q;

    // Per-spot clamp and window test against the active position
    generate
        for (genvar gi = 0; gi < NUM_SPOTS; gi++) begin : g_spot
            logic signed [31:0] x_raw, y_raw;
            logic signed [16:0] ddx, ddy;
            logic               in_x, in_y;

            assign x_raw = $signed(pix_x_in[32*gi +: 32]);
            assign y_raw = $signed(pix_y_in[32*gi +: 32]);
            assign x_clamp[gi] = clamp(x_raw, H_RES - 1);
            assign y_clamp[gi] = clamp(y_raw, V_RES - 1);

            assign ddx  = $signed({h_cnt[15], h_cnt}) - $signed({1'b0, act_x_q[gi]});
            assign ddy  = $signed({v_cnt[15], v_cnt}) - $signed({1'b0, act_y_q[gi]});
            assign in_x = (ddx >= RAD_N) && (ddx <= RAD_P);
            assign in_y = (ddy >= RAD_N) && (ddy <= RAD_P);

            assign spot_hit[gi] = act_en_q[gi] && in_x && in_y;
            assign spot_dx[gi]  = OFF_W'(ddx + RAD_P);
            assign spot_dy[gi]  = OFF_W'(ddy + RAD_P);
        end
    endgenerate

    // Shadow capture on ena; shadow-to-active transfer on vs rising edge
    always_comb begin
        shadow_x_d  = shadow_x_q;
        shadow_y_d  = shadow_y_q;
        shadow_en_d = shadow_en_q;
        act_x_d     = act_x_q;
        act_y_d     = act_y_q;
        act_en_d    = act_en_q;
        if (ena) begin
            shadow_x_d  = x_clamp;
            shadow_y_d  = y_clamp;
            shadow_en_d = spot_en;
        end
        if (commit) begin
            act_x_d  = shadow_x_q;
            act_y_d  = shadow_y_q;
            act_en_d = shadow_en_q;
        end
    end

    // S1 next state: register raw hit vector and sprite offsets
    always_comb begin
        s1_hit_d = spot_hit;
        s1_dx_d  = spot_dx;
        s1_dy_d  = spot_dy;
    end

    // S2: lowest-index hit wins; scan from the top so lower indices overwrite
    always_comb begin
        sel_idx = NO_HIT;
        sel_dx  = '0;
        sel_dy  = '0;
        for (int k = NUM_SPOTS - 1; k >= 0; k--) begin
            if (s1_hit_q[k]) begin
                sel_idx = HIT_W'(k);
                sel_dx  = s1_dx_q[k];
                sel_dy  = s1_dy_q[k];
            end
        end
        s2_idx_d   = sel_idx;
        rom_addr_d = (sel_idx == NO_HIT) ? '0
                   : ADDR_W'(int'(sel_dy) * SPOT_SIZE + int'(sel_dx));
    end

    // Delay-line shifting for timing, background, mode and hit index
    always_comb begin
        tm_d[0] = {blend_mode, de_in, hs_in, vs_in, bg_rgb};
        for (int i = 1; i < LAT; i++)
            tm_d[i] = tm_q[i-1];
        hit_d[0] = s2_idx_q;
        for (int i = 1; i < ROM_LAT; i++)
            hit_d[i] = hit_q[i-1];
    end

    // All state registers
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            shadow_x_q  <= '0;
            shadow_y_q  <= '0;
            shadow_en_q <= '0;
            act_x_q     <= '0;
            act_y_q     <= '0;
            act_en_q    <= '0;
            vs_prev_q   <= 1'b0;
            s1_hit_q    <= '0;
            s1_dx_q     <= '0;
            s1_dy_q     <= '0;
            rom_addr_q  <= '0;
            s2_idx_q    <= NO_HIT;
            tm_q        <= '0;
            hit_q       <= '1;
        end else begin
            shadow_x_q  <= shadow_x_d;
            shadow_y_q  <= shadow_y_d;
            shadow_en_q <= shadow_en_d;
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
            act_en_q    <= act_en_d;
            vs_prev_q   <= vs_in;
            s1_hit_q    <= s1_hit_d;
            s1_dx_q     <= s1_dx_d;
            s1_dy_q     <= s1_dy_d;
            rom_addr_q  <= rom_addr_d;
            s2_idx_q    <= s2_idx_d;
            tm_q        <= tm_d;
            hit_q       <= hit_d;
        end
    end

    assign {mode_dly, de_dly, hs_dly, vs_dly, bg_dly} = tm_q[LAT-1];
    assign pix_hit = (hit_q[ROM_LAT-1] != NO_HIT);

    assign r_sum = {1'b0, bg_dly[15:11]} + {1'b0, rom_data[15:11]};
    assign g_sum = {1'b0, bg_dly[10:5]}  + {1'b0, rom_data[10:5]};
    assign b_sum = {1'b0, bg_dly[4:0]}   + {1'b0, rom_data[4:0]};

    // Final mix: blanking -> black, miss/transparent -> background, else sprite
    always_comb begin
        rgb_out = 16'h0000;
        if (de_dly) begin
            if (!pix_hit || rom_data == TRANSP)
                rgb_out = bg_dly;
            else if (!mode_dly)
                rgb_out = rom_data;
            else
                rgb_out = {r_sum[5:1], g_sum[6:1], b_sum[5:1]};
        end
    end

    assign rom_addr = rom_addr_q;
    assign de_out   = de_dly;
    assign hs_out   = hs_dly;
    assign vs_out   = vs_dly;
    assign hit_idx  = hit_q[ROM_LAT-1];

endmodule

// File: tb/tb_hotspot_overlay_multi.sv
// Directed bench for hotspot_overlay_multi with a 1-cycle registered sprite ROM.
module tb_hotspot_overlay_multi;

    localparam int NS = 4;

    logic              clk_pix = 1'b0;
    logic              rst_n;
    logic              ena;
    logic [32*NS-1:0]  pix_x_in;
    logic [32*NS-1:0]  pix_y_in;
    logic [NS-1:0]     spot_en;
    logic              blend_mode;
    logic [15:0]       h_cnt, v_cnt;
    logic              de_in, hs_in, vs_in;
    logic [15:0]       bg_rgb;
    logic [11:0]       rom_addr;
    logic [15:0]       rom_data;
    logic              de_out, hs_out, vs_out;
    logic [15:0]       rgb_out;
    logic [2:0]        hit_idx;

    logic [15:0] rom_mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_pix = ~clk_pix;

    // Sprite ROM model, one cycle registered read
    always @(posedge clk_pix) rom_data <= rom_mem[rom_addr];

    hotspot_overlay_multi dut (
        .clk_pix    (clk_pix),
        .rst_n      (rst_n),
        .ena        (ena),
        .pix_x_in   (pix_x_in),
        .pix_y_in   (pix_y_in),
        .spot_en    (spot_en),
        .blend_mode (blend_mode),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .de_in      (de_in),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .bg_rgb     (bg_rgb),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .de_out     (de_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .rgb_out    (rgb_out),
        .hit_idx    (hit_idx)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic idle();
        de_in      = 1'b0;
        hs_in      = 1'b0;
        h_cnt      = 16'(-1000);
        v_cnt      = 16'(-1000);
        bg_rgb     = 16'h0000;
        blend_mode = 1'b0;
    endtask

    task automatic set_spot(input int k, input int x, input int y);
        pix_x_in[32*k +: 32] = 32'(x);
        pix_y_in[32*k +: 32] = 32'(y);
    endtask

    task automatic strobe(input logic [NS-1:0] en);
        spot_en = en;
        ena     = 1'b1;
        step();
        ena     = 1'b0;
    endtask

    // vs pulse; optionally raise ena in the same cycle as the commit edge
    task automatic frame_start(input logic with_ena);
        idle();
        vs_in = 1'b0;
        step();
        vs_in = 1'b1;
        if (with_ena) ena = 1'b1;
        step();
        vs_in = 1'b0;
        ena   = 1'b0;
        step();
        step();
        check_eq("vs_out_delay", {31'd0, vs_out}, 32'd1);
        step();
    endtask

    // One active pixel surrounded by blanking; address checked 2 cycles later,
    // composited output checked exactly 3 cycles later
    task automatic pix(input string tag, input int h, input int v, input logic [15:0] bg,
                       input logic mode, input int exp_addr, input logic [15:0] exp_rgb,
                       input logic [2:0] exp_hit);
        h_cnt      = 16'(h);
        v_cnt      = 16'(v);
        de_in      = 1'b1;
        hs_in      = 1'b1;
        bg_rgb     = bg;
        blend_mode = mode;
        step();
        idle();
        step();
        check_eq({tag, "_addr"}, {20'd0, rom_addr}, 32'(exp_addr));
        step();
        check_eq({tag, "_rgb"}, {16'd0, rgb_out}, {16'd0, exp_rgb});
        check_eq({tag, "_hit"}, {29'd0, hit_idx}, {29'd0, exp_hit});
        check_eq({tag, "_de_hs"}, {30'd0, de_out, hs_out}, 32'd3);
        $display("pix %-22s h=%0d v=%0d addr=%0d rgb=%04h hit=%0d", tag, h, v,
                 exp_addr, rgb_out, hit_idx);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 4096; a++) rom_mem[a] = 16'(32'h1000 + a);
        rst_n    = 1'b0;
        ena      = 1'b0;
        vs_in    = 1'b0;
        spot_en  = '0;
        pix_x_in = '0;
        pix_y_in = '0;
        idle();
        repeat (3) step();

        // Reset state
        check_eq("rst_rgb", {16'd0, rgb_out}, 32'd0);
        check_eq("rst_hit", {29'd0, hit_idx}, 32'd7);
        check_eq("rst_addr", {20'd0, rom_addr}, 32'd0);
        check_eq("rst_timing", {29'd0, de_out, hs_out, vs_out}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: basic placement and window edges
        set_spot(0, 100, 50);
        strobe(4'b0001);
        frame_start(1'b0);
        pix("t1_center",     100, 50, 16'hAAAA, 1'b0, 1200, rom_mem[1200], 3'd0);
        pix("t1_left_miss",   75, 50, 16'hBBBB, 1'b0,    0, 16'hBBBB,      3'd7);
        pix("t1_left_edge",   76, 50, 16'hCCCC, 1'b0, 1176, rom_mem[1176], 3'd0);
        pix("t1_corner",     124, 74, 16'hCCCC, 1'b0, 2400, rom_mem[2400], 3'd0);
        pix("t1_below_miss", 100, 75, 16'hDDDD, 1'b0,    0, 16'hDDDD,      3'd7);

        // 2: clamping and edge clipping without wrap
        set_spot(0, -5, 300);
        strobe(4'b0001);
        frame_start(1'b0);
        pix("t2_clip_center",  0, 271, 16'h1111, 1'b0, 1200, rom_mem[1200], 3'd0);
        pix("t2_clip_top",     0, 247, 16'h1111, 1'b0,   24, rom_mem[24],   3'd0);
        pix("t2_clip_right",  24, 271, 16'h1111, 1'b0, 1224, rom_mem[1224], 3'd0);
        pix("t2_clip_miss",   25, 271, 16'h2222, 1'b0,    0, 16'h2222,      3'd7);
        set_spot(0, 600, 300);
        strobe(4'b0001);
        frame_start(1'b0);
        pix("t2_xmax_center", 479, 271, 16'h3333, 1'b0, 1200, rom_mem[1200], 3'd0);
        pix("t2_xmax_left",   455, 271, 16'h3333, 1'b0, 1176, rom_mem[1176], 3'd0);
        pix("t2_no_wrap",       0, 271, 16'h4444, 1'b0,    0, 16'h4444,      3'd7);

        // 3: overlap priority
        set_spot(0, 200, 100);
        set_spot(1, 210, 100);
        strobe(4'b0011);
        frame_start(1'b0);
        pix("t3_overlap",    205, 100, 16'h5555, 1'b0, 1205, rom_mem[1205], 3'd0);
        pix("t3_spot1_only", 230, 100, 16'h5555, 1'b0, 1220, rom_mem[1220], 3'd1);
        strobe(4'b0010);
        frame_start(1'b0);
        pix("t3_spot0_off",  205, 100, 16'h5555, 1'b0, 1195, rom_mem[1195], 3'd1);

        // 4: double buffering
        set_spot(0, 100, 50);
        strobe(4'b0001);
        frame_start(1'b0);
        set_spot(0, 300, 50);
        strobe(4'b0001);
        pix("t4_old_pos",     100, 50, 16'h6666, 1'b0, 1200, rom_mem[1200], 3'd0);
        pix("t4_new_pending", 300, 50, 16'h6666, 1'b0,    0, 16'h6666,      3'd7);
        frame_start(1'b0);
        pix("t4_new_pos",     300, 50, 16'h6666, 1'b0, 1200, rom_mem[1200], 3'd0);
        pix("t4_old_gone",    100, 50, 16'h7777, 1'b0,    0, 16'h7777,      3'd7);
        set_spot(0, 150, 50);
        frame_start(1'b1);
        pix("t4_ena_commit_old", 300, 50, 16'h7777, 1'b0, 1200, rom_mem[1200], 3'd0);
        pix("t4_ena_commit_new", 150, 50, 16'h8888, 1'b0,    0, 16'h8888,      3'd7);
        frame_start(1'b0);
        pix("t4_applied",        150, 50, 16'h8888, 1'b0, 1200, rom_mem[1200], 3'd0);

        // 5: blend and transparency
        rom_mem[1200] = 16'h001F;
        rom_mem[1201] = 16'h0000;
        pix("t5_blend",     150, 50, 16'hF800, 1'b1, 1200, 16'h780F, 3'd0);
        pix("t5_blend_wht", 150, 50, 16'hFFFF, 1'b1, 1200, 16'h7BFF, 3'd0);
        pix("t5_transp",    151, 50, 16'hF800, 1'b1, 1201, 16'hF800, 3'd0);
        pix("t5_opaque",    150, 50, 16'hF800, 1'b0, 1200, 16'h001F, 3'd0);

        // 6: asynchronous reset mid-line
        h_cnt      = 16'd150;
        v_cnt      = 16'd50;
        de_in      = 1'b1;
        hs_in      = 1'b0;
        bg_rgb     = 16'h1234;
        blend_mode = 1'b0;
        repeat (3) step();
        check_eq("t6_pre_rgb", {16'd0, rgb_out}, 32'h001F);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_rgb", {16'd0, rgb_out}, 32'd0);
        check_eq("t6_async_hit", {29'd0, hit_idx}, 32'd7);
        check_eq("t6_async_addr", {20'd0, rom_addr}, 32'd0);
        check_eq("t6_async_de", {31'd0, de_out}, 32'd0);
        @(posedge clk_pix);
        #1;
        rst_n = 1'b1;
        repeat (4) step();
        check_eq("t6_post_rgb", {16'd0, rgb_out}, 32'h1234);
        check_eq("t6_post_hit", {29'd0, hit_idx}, 32'd7);
        $display("t6 reset release rgb=%04h hit=%0d", rgb_out, hit_idx);
        idle();
        set_spot(0, 150, 50);
        strobe(4'b0001);
        pix("t6_ena_only", 150, 50, 16'h1234, 1'b0, 0, 16'h1234, 3'd7);
        frame_start(1'b0);
        pix("t6_restored", 150, 50, 16'h1234, 1'b0, 1200, 16'h001F, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
